hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller. Drives the hold/flush inputs of the PC, IF/ID, ID/EX and EX/MEM
//  registers. The ID/EX register consumes idex_clr as its clr input.
//  Detects load-use hazards, taken branches/jumps resolved in EX, and multi-cycle multiply
//  occupancy of EX. It inserts bubbles or stalls so younger instructions never see stale data.
// PARAMETERS
//  MUL_LAT  4  cycles a multiply occupies EX (legal range 1..16; 1 = single-cycle, no stall)
// PORTS
//  clk           in   1  rising-edge clock
//  rst_n         in   1  synchronous active-low reset
//  id_rs         in   5  rs field of instruction in ID (Inst[25:21])
//  id_rt         in   5  rt field of instruction in ID (Inst[20:16])
//  id_use_rs     in   1  ID instruction reads rs
//  id_use_rt     in   1  ID instruction reads rt
//  ex_dst        in   5  destination register of EX instruction (after RegDst mux)
//  ex_regwr      in   1  EX instruction writes the register file (RegWr_f)
//  ex_memtoreg   in   1  EX instruction is a load (MemtoReg_f)
//  ex_br_taken   in   1  branch taken or jump resolved in EX this cycle
//  ex_mul_start  in   1  first EX cycle of a multiply (single-cycle pulse)
//  pc_wr         out  1  1 = PC updates; 0 = PC holds
//  ifid_wr       out  1  1 = IF/ID loads; 0 = IF/ID holds
//  ifid_clr      out  1  zero IF/ID at next edge
//  idex_wr       out  1  1 = ID/EX loads; 0 = ID/EX holds
//  idex_clr      out  1  zero ID/EX at next edge (bubble)
//  exmem_clr     out  1  zero EX/MEM at next edge (bubble behind a held EX)
//  busy          out  1  multiply stall in progress (state MUL)
// BEHAVIOUR
//  - All outputs are combinational from state and inputs (0-cycle latency). State and cnt are registered.
//  - Reset (rst_n=0 at posedge): state<=RUN, cnt<=0. While rst_n=0, outputs are forced:
//    pc_wr=0, ifid_wr=0, idex_wr=0, ifid_clr=1, idex_clr=1, exmem_clr=1, busy=0.
//  - Default (RUN, no hazard): pc_wr=ifid_wr=idex_wr=1; all clr=0; busy=0.
//  - Priority in RUN: branch > mul_start > load-use.
//  - Branch (ex_br_taken=1): ifid_clr=1, idex_clr=1, pc_wr=1 (loads target).
//    A coincident load-use or mul_start in the same cycle is ignored.
//  - Multiply start (ex_mul_start=1, MUL_LAT>1): pc_wr=ifid_wr=idex_wr=0, exmem_clr=1.
//    Next state is MUL with cnt<=MUL_LAT-2.
//    If MUL_LAT==1, ex_mul_start is ignored.
//  - MUL: busy=1. While cnt!=0: hold outputs as at multiply start, and cnt decrements.
//    When cnt==0 (release cycle): outputs take default values and the next state is RUN.
//    Result: total hold cycles = MUL_LAT-1; EX occupancy = MUL_LAT cycles.
//    In MUL, ex_br_taken and ex_mul_start are ignored; load-use is ignored because EX holds the multiply.
//  - Load-use: hazard when ex_memtoreg & ex_regwr & ex_dst!=0 & ((id_use_rs & id_rs==ex_dst) |
//    (id_use_rt & id_rt==ex_dst)). Response: pc_wr=0, ifid_wr=0, idex_clr=1 for exactly one cycle;
//    idex_wr=1. The load then leaves EX, so the hazard clears by itself.
//  - ex_dst==0 never causes a stall.
//  - Reset during MUL aborts the stall; the first cycle after reset is RUN with busy=0.
//  - cnt width is $clog2(MUL_LAT), minimum 1 bit.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds two output ports.
//    stall_cnt out 32: counts cycles with rst_n=1 & pc_wr=0.
//    flush_cnt out 32: counts cycles with a branch flush.
//    Both reset to 0 and saturate at 32'hFFFF_FFFF (no wrap).
//  HAZARD_PERF_EN undefined: these ports and their counters do not exist. All other behaviour is identical.
// TESTING
//  1 Load-use: ex_memtoreg=1, ex_regwr=1, ex_dst=5, id_rs=5, id_use_rs=1
//    -> pc_wr=0, ifid_wr=0, idex_clr=1 for one cycle, then defaults. Repeat with ex_dst=0 -> no stall.
//  2 Branch and load-use in the same cycle: ex_br_taken=1 with the case-1 inputs
//    -> ifid_clr=1, idex_clr=1, pc_wr=1, ifid_wr=1.
//  3 MUL_LAT=4: ex_mul_start pulse at cycle 0 -> pc_wr=0 and exmem_clr=1 in cycles 0-2;
//    busy=1 in cycles 1-3; pc_wr=1 in cycle 3; RUN in cycle 4.
//  4 Reset mid-multiply: rst_n=0 at cycle 1 of a MUL_LAT=4 stall -> outputs forced to reset values;
//    after rst_n=1, busy=0 and pc_wr=1.
//  5 MUL_LAT=1: ex_mul_start=1 -> no stall and busy stays 0.
//  6 HAZARD_PERF_EN: 3 load-use stalls + 2 branches -> stall_cnt=3, flush_cnt=2.
//    Force stall_cnt to 32'hFFFF_FFFF, then apply one stall -> value unchanged.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard controller pipeline-side signal bundle
interface hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] ex_dst;
  logic       ex_regwr;
  logic       ex_memtoreg;
  logic       ex_br_taken;
  logic       ex_mul_start;
  logic       pc_wr;
  logic       ifid_wr;
  logic       ifid_clr;
  logic       idex_wr;
  logic       idex_clr;
  logic       exmem_clr;
  logic       busy;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_dst, ex_regwr, ex_memtoreg,
           ex_br_taken, ex_mul_start,
    input  pc_wr, ifid_wr, ifid_clr, idex_wr, idex_clr, exmem_clr, busy
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_dst, ex_regwr, ex_memtoreg,
           ex_br_taken, ex_mul_start,
    output pc_wr, ifid_wr, ifid_clr, idex_wr, idex_clr, exmem_clr, busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / branch / multiply hazard controller
// HAZARD_PERF_EN adds saturating stall_cnt and flush_cnt outputs.
module hazard_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]  stall_cnt,
  output logic [31:0]  flush_cnt
`endif
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] C_LOAD = CW'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

  typedef enum logic {S_RUN, S_MUL} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_load_use;
  logic          w_flush;
  logic          w_pc_wr, w_ifid_wr, w_ifid_clr, w_idex_wr, w_idex_clr, w_exmem_clr, w_busy;

  always_comb begin
    w_load_use = hz.ex_memtoreg && hz.ex_regwr && (hz.ex_dst != 5'd0) &&
                 ((hz.id_use_rs && (hz.id_rs == hz.ex_dst)) ||
                  (hz.id_use_rt && (hz.id_rt == hz.ex_dst)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_flush     = 1'b0;
    w_pc_wr     = 1'b1;
    w_ifid_wr   = 1'b1;
    w_ifid_clr  = 1'b0;
    w_idex_wr   = 1'b1;
    w_idex_clr  = 1'b0;
    w_exmem_clr = 1'b0;
    w_busy      = 1'b0;
    if (!rst_n) begin
      w_pc_wr     = 1'b0;
      w_ifid_wr   = 1'b0;
      w_idex_wr   = 1'b0;
      w_ifid_clr  = 1'b1;
      w_idex_clr  = 1'b1;
      w_exmem_clr = 1'b1;
    end else begin
      case (r_state)
        S_RUN: begin
          if (hz.ex_br_taken) begin
            w_ifid_clr = 1'b1;
            w_idex_clr = 1'b1;
            w_flush    = 1'b1;
          end else if (hz.ex_mul_start && (MUL_LAT > 1)) begin
            w_pc_wr     = 1'b0;
            w_ifid_wr   = 1'b0;
            w_idex_wr   = 1'b0;
            w_exmem_clr = 1'b1;
            w_state_nxt = S_MUL;
            w_cnt_nxt   = C_LOAD;
          end else if (w_load_use) begin
            w_pc_wr    = 1'b0;
            w_ifid_wr  = 1'b0;
            w_idex_clr = 1'b1;
          end
        end
        S_MUL: begin
          // cnt==0 is the release cycle: the multiply leaves EX at this edge
          w_busy = 1'b1;
          if (r_cnt != '0) begin
            w_pc_wr     = 1'b0;
            w_ifid_wr   = 1'b0;
            w_idex_wr   = 1'b0;
            w_exmem_clr = 1'b1;
            w_cnt_nxt   = r_cnt - 1'b1;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  assign hz.pc_wr     = w_pc_wr;
  assign hz.ifid_wr   = w_ifid_wr;
  assign hz.ifid_clr  = w_ifid_clr;
  assign hz.idex_wr   = w_idex_wr;
  assign hz.idex_clr  = w_idex_clr;
  assign hz.exmem_clr = w_exmem_clr;
  assign hz.busy      = w_busy;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_wr && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl (MUL_LAT=4 and MUL_LAT=1)
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if hz4();
  hazard_ctrl_if hz1();

`ifdef HAZARD_PERF_EN
  logic [31:0] stall4, flush4, stall1, flush1;
`endif

  hazard_ctrl #(.MUL_LAT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .hz(hz4)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall4), .flush_cnt(flush4)
`endif
  );

  hazard_ctrl #(.MUL_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .hz(hz1)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall1), .flush_cnt(flush1)
`endif
  );

  // {pc_wr, ifid_wr, ifid_clr, idex_wr, idex_clr, exmem_clr, busy}
  localparam logic [6:0] O_RST  = 7'b0010110;
  localparam logic [6:0] O_DEF  = 7'b1101000;
  localparam logic [6:0] O_BR   = 7'b1111100;
  localparam logic [6:0] O_MST  = 7'b0000010;
  localparam logic [6:0] O_HOLD = 7'b0000011;
  localparam logic [6:0] O_REL  = 7'b1101001;
  localparam logic [6:0] O_LU   = 7'b0001100;

  typedef struct packed {
    logic [6:0] e4;
    logic [6:0] e1;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  // Multiply cycles still owed after the start cycle, per latency
  int rem4 = 0;
  int rem1 = 0;
  int m_stall = 0;
  int m_flush = 0;

  logic [4:0] t_rs, t_rt, t_dst;
  logic t_urs, t_urt, t_rw, t_m2r, t_br, t_mul;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_out(input int lat, input int rem, input logic rst);
    logic lu;
    lu = t_m2r && t_rw && (t_dst != 0) &&
         ((t_urs && t_rs == t_dst) || (t_urt && t_rt == t_dst));
    if (!rst) return O_RST;
    if (rem > 0) return (rem > 1) ? O_HOLD : O_REL;
    if (t_br) return O_BR;
    if (t_mul && lat > 1) return O_MST;
    if (lu) return O_LU;
    return O_DEF;
  endfunction

  function automatic int ref_rem(input int lat, input int rem, input logic rst);
    if (!rst) return 0;
    if (rem > 0) return rem - 1;
    if (!t_br && t_mul && lat > 1) return lat - 1;
    return 0;
  endfunction

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic [4:0] dst, input logic rw,
                        input logic m2r, input logic br, input logic mul);
    t_rs = rs; t_rt = rt; t_urs = urs; t_urt = urt; t_dst = dst;
    t_rw = rw; t_m2r = m2r; t_br = br; t_mul = mul;
  endtask

  task automatic idle_in();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cycle(input logic rst);
    exp_t e;
    rst_n = rst;
    hz4.id_rs = t_rs; hz4.id_rt = t_rt; hz4.id_use_rs = t_urs; hz4.id_use_rt = t_urt;
    hz4.ex_dst = t_dst; hz4.ex_regwr = t_rw; hz4.ex_memtoreg = t_m2r;
    hz4.ex_br_taken = t_br; hz4.ex_mul_start = t_mul;
    hz1.id_rs = t_rs; hz1.id_rt = t_rt; hz1.id_use_rs = t_urs; hz1.id_use_rt = t_urt;
    hz1.ex_dst = t_dst; hz1.ex_regwr = t_rw; hz1.ex_memtoreg = t_m2r;
    hz1.ex_br_taken = t_br; hz1.ex_mul_start = t_mul;
    e.e4 = ref_out(4, rem4, rst);
    e.e1 = ref_out(1, rem1, rst);
    sb.push_back(e);
    if (!rst) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!e.e4[6]) m_stall++;
      if (e.e4 == O_BR) m_flush++;
    end
    rem4 = ref_rem(4, rem4, rst);
    rem1 = ref_rem(1, rem1, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_in(input logic [4:0] dst);
    set_in(dst, 5'd9, 1'b1, 1'b0, dst, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("outputs_lat4", {25'd0, hz4.pc_wr, hz4.ifid_wr, hz4.ifid_clr, hz4.idex_wr,
                               hz4.idex_clr, hz4.exmem_clr, hz4.busy}, {25'd0, e.e4});
        check("outputs_lat1", {25'd0, hz1.pc_wr, hz1.ifid_wr, hz1.ifid_clr, hz1.idex_wr,
                               hz1.idex_clr, hz1.exmem_clr, hz1.busy}, {25'd0, e.e1});
      end
    end
  end

  initial begin
    idle_in();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b0);
    cycle(1'b0);
    idle_in(); cycle(1'b1);

    load_use_in(5'd5); cycle(1'b1);
    idle_in(); cycle(1'b1);
    load_use_in(5'd0); cycle(1'b1);
    set_in(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0); cycle(1'b1);
    set_in(5'd7, 5'd1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0); cycle(1'b1);
    idle_in(); cycle(1'b1);

    load_use_in(5'd5); t_br = 1'b1; cycle(1'b1);
    idle_in(); cycle(1'b1);

    idle_in(); t_mul = 1'b1; cycle(1'b1);
    idle_in();
    repeat (5) cycle(1'b1);

    t_mul = 1'b1; cycle(1'b1);
    idle_in(); t_br = 1'b1; cycle(1'b1);
    cycle(1'b0);
    idle_in(); cycle(1'b0);
    repeat (2) cycle(1'b1);

    t_mul = 1'b1; cycle(1'b1);
    load_use_in(5'd5); t_br = 1'b1; t_mul = 1'b1;
    repeat (3) cycle(1'b1);
    idle_in(); cycle(1'b1);

    for (int i = 0; i < 400; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
      cycle($urandom_range(0, 39) != 0);
    end

`ifdef HAZARD_PERF_EN
    idle_in(); cycle(1'b0);
    repeat (3) begin
      load_use_in(5'd5); cycle(1'b1);
      idle_in(); cycle(1'b1);
    end
    repeat (2) begin
      idle_in(); t_br = 1'b1; cycle(1'b1);
      idle_in(); cycle(1'b1);
    end
    check("stall_cnt", stall4, 32'd3);
    check("flush_cnt", flush4, 32'd2);
    check("stall_cnt_model", stall4, 32'(m_stall));
    check("flush_cnt_model", flush4, 32'(m_flush));
    force u_dut4.r_stall_cnt = 32'hFFFF_FFFF;
    #2;
    release u_dut4.r_stall_cnt;
    load_use_in(5'd5); cycle(1'b1);
    idle_in(); cycle(1'b1);
    check("stall_cnt_sat", stall4, 32'hFFFF_FFFF);
`endif

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
